// File: rtl/bexkat_intctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : bexkat_intctrl
//  Purpose  : Memory-mapped priority interrupt controller. Latches up to seven
//             request lines (level or edge per line), masks them and presents
//             the highest pending unmasked line to the CPU as a 3-bit level.
//  Config   : BEXKAT_INTCTRL_SYNC_EN - when defined, irq passes through a
//             2-flop synchronizer before edge detection.
//  Revision : 1.0 - initial release
// ============================================================================
module bexkat_intctrl #(
   parameter int NUM_SRC = 7
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  irq,
   input  logic        int_en,
   output logic [2:0]  interrupt,
   input  logic        chipselect,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        waitrequest
);

   // Lines above NUM_SRC never latch or store anything, so they read 0.
   localparam logic [6:0] LINE_VALID = 7'((1 << NUM_SRC) - 1);

   localparam logic [1:0] ADDR_PEND = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE = 2'd2;
   localparam logic [1:0] ADDR_CUR  = 2'd3;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RDWAIT = 1'b1
   } bus_state_t;

   bus_state_t state;
   bus_state_t next_state;

   logic [6:0]  s;
   logic [6:0]  s_d;
   logic [6:0]  rise;
   logic [6:0]  pend;
   logic [6:0]  mask;
   logic [6:0]  edge_cfg;
   logic [6:0]  active;
   logic [6:0]  wdat;
   logic [6:0]  clr;
   logic [6:0]  pend_next;
   logic [2:0]  cur;
   logic [31:0] rd_mux;
   logic        rd_start;
   logic        wr_en;
   logic        unused_bits;

`ifdef BEXKAT_INTCTRL_SYNC_EN
   logic [6:0] sync1;
   logic [6:0] sync2;

   // Two-flop synchronizer: irq is asynchronous to clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 7'd0;
         sync2 <= 7'd0;
      end else begin
         sync1 <= irq;
         sync2 <= sync1;
      end
   end

   assign s = sync2;
`else
   // Source already synchronous to clk: use it directly.
   assign s = irq;
`endif

   // Previous-cycle copy of the sampled requests for rising-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) s_d <= 7'd0;
      else          s_d <= s;
   end

   assign rise = s & ~s_d;

   // Bus decode: writes only land in IDLE and lose to a simultaneous read.
   assign rd_start = (state == IDLE) && chipselect && read;
   assign wr_en    = (state == IDLE) && chipselect && write && !read && byteenable[0];
   assign wdat     = writedata[7:1];
   assign clr      = (wr_en && (address == ADDR_PEND)) ? wdat : 7'd0;

   // Edge lines: rising edge sets (and beats a same-cycle clear), write-1 clears.
   // Level lines: pending simply follows the sampled input.
   assign pend_next = ((edge_cfg & (rise | (pend & ~clr))) | (~edge_cfg & s)) & LINE_VALID;

   // Pending register update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pend <= 7'd0;
      else          pend <= pend_next;
   end

   // MASK and EDGE configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask     <= 7'd0;
         edge_cfg <= 7'd0;
      end else if (wr_en) begin
         if (address == ADDR_MASK) mask     <= wdat & LINE_VALID;
         if (address == ADDR_EDGE) edge_cfg <= wdat & LINE_VALID;
      end
   end

   assign active = pend & mask;

   // Priority encode: highest pending unmasked line wins, 0 when none.
   always_comb begin
      cur = 3'd0;
      for (int k = 1; k <= 7; k++) begin
         if (active[k-1]) cur = 3'(k);
      end
   end

   // Registered level to the CPU, gated by the CPU interrupt enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) interrupt <= 3'd0;
      else          interrupt <= int_en ? cur : 3'd0;
   end

   // Read data selection; CUR returns the encoded level in the low bits.
   always_comb begin
      rd_mux = 32'd0;
      case (address)
         ADDR_PEND: rd_mux = {24'h0, pend, 1'b0};
         ADDR_MASK: rd_mux = {24'h0, mask, 1'b0};
         ADDR_EDGE: rd_mux = {24'h0, edge_cfg, 1'b0};
         ADDR_CUR:  rd_mux = {29'h0, cur};
         default:   rd_mux = 32'd0;
      endcase
   end

   // Bus state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Bus FSM: a read stalls one cycle while readdata is registered.
   always_comb begin
      next_state  = state;
      waitrequest = 1'b0;
      case (state)
         IDLE: begin
            if (chipselect && read) begin
               waitrequest = 1'b1;
               next_state  = RDWAIT;
            end
         end
         RDWAIT: begin
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Read data capture; holds its value between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      readdata <= 32'd0;
      else if (rd_start) readdata <= rd_mux;
   end

   assign unused_bits = &{1'b0, writedata[31:8], writedata[0], byteenable[3:1]};

endmodule
`default_nettype wire

// File: tb/tb_bexkat_intctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bexkat_intctrl
//  Purpose  : Self-checking bench for bexkat_intctrl with a line-by-line
//             behavioural model of pending/mask/edge state and bus timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bexkat_intctrl;

`ifdef BEXKAT_INTCTRL_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT = SYNC + 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [6:0]  irq;
   logic        int_en;
   logic [2:0]  interrupt;
   logic        chipselect;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [6:0] m_pend, m_mask, m_edge, m_sd, m_h0, m_h1;
   logic [2:0] m_int;
   bit         m_rdwait;

   bexkat_intctrl #(.NUM_SRC(7)) dut (
      .clk(clk), .reset_n(reset_n), .irq(irq), .int_en(int_en),
      .interrupt(interrupt), .chipselect(chipselect), .address(address),
      .read(read), .write(write), .byteenable(byteenable),
      .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] cur_of(input logic [6:0] p, input logic [6:0] m);
      for (int k = 7; k >= 1; k--)
         if (p[k-1] && m[k-1]) return 3'(k);
      return 3'd0;
   endfunction

   function automatic logic [31:0] reg_of(input logic [1:0] a);
      case (a)
         2'd0:    return {24'h0, m_pend, 1'b0};
         2'd1:    return {24'h0, m_mask, 1'b0};
         2'd2:    return {24'h0, m_edge, 1'b0};
         default: return {29'h0, cur_of(m_pend, m_mask)};
      endcase
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_edge = '0; m_sd = '0;
      m_h0 = '0; m_h1 = '0; m_int = '0; m_rdwait = 0;
   endtask

   // One clock: predict the next state from the current inputs, then check.
   task automatic step();
      logic [6:0] s, pn, clr, nm, ne, irq_now;
      logic [2:0] ni;
      bit wr, nrd;
      #1;
      chk("waitrequest", {31'h0, waitrequest}, {31'h0, (!m_rdwait && chipselect && read)});
      irq_now = irq;
      s   = (SYNC == 2) ? m_h1 : irq_now;
      wr  = !m_rdwait && chipselect && write && !read && byteenable[0];
      clr = (wr && address == 2'd0) ? writedata[7:1] : 7'h0;
      for (int k = 0; k < 7; k++) begin
         if (m_edge[k]) begin
            if (s[k] && !m_sd[k]) pn[k] = 1'b1;
            else if (clr[k])      pn[k] = 1'b0;
            else                  pn[k] = m_pend[k];
         end else begin
            pn[k] = s[k];
         end
      end
      nm  = (wr && address == 2'd1) ? writedata[7:1] : m_mask;
      ne  = (wr && address == 2'd2) ? writedata[7:1] : m_edge;
      ni  = int_en ? cur_of(m_pend, m_mask) : 3'd0;
      nrd = !m_rdwait && chipselect && read;
      @(posedge clk);
      #1;
      m_pend = pn; m_mask = nm; m_edge = ne; m_int = ni; m_rdwait = nrd;
      m_sd = s; m_h1 = m_h0; m_h0 = irq_now;
      chk("interrupt", {29'h0, interrupt}, {29'h0, m_int});
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      chipselect = 1; write = 1; address = a; writedata = d; byteenable = be;
      step();
      chipselect = 0; write = 0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      logic [31:0] exp;
      chipselect = 1; read = 1; address = a;
      exp = reg_of(a);
      step();
      chk("readdata", readdata, exp);
      d = readdata;
      chipselect = 0; read = 0;
      step();
   endtask

   task automatic do_reset();
      reset_n = 0;
      irq = '0; int_en = 1; chipselect = 0; address = '0; read = 0; write = 0;
      byteenable = '0; writedata = '0;
      #1;
      model_reset();
      chk("reset_interrupt", {29'h0, interrupt}, 32'h0);
      chk("reset_readdata", readdata, 32'h0);
      chk("reset_waitrequest", {31'h0, waitrequest}, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
   endtask

   initial begin
      logic [31:0] d;
      do_reset();

      // 1: first read of CUR after reset stalls one clock and returns 0
      chipselect = 1; read = 1; address = 2'd3;
      #1 chk("t1_wait_high", {31'h0, waitrequest}, 32'h1);
      step();
      chk("t1_wait_low", {31'h0, waitrequest}, 32'h0);
      chk("t1_cur", readdata, 32'h0);
      chipselect = 0; read = 0;
      step();

      // 2: level line 3
      bus_write(2'd1, 32'hFE, 4'hF);
      bus_write(2'd2, 32'h00, 4'hF);
      irq = 7'b0000100;
      repeat (LAT - 1) step();
      chk("t2_before", {29'h0, interrupt}, 32'h0);
      step();
      chk("t2_level3", {29'h0, interrupt}, 32'h3);
      irq = 7'b0;
      repeat (LAT) step();
      chk("t2_drop", {29'h0, interrupt}, 32'h0);

      // 3: edge lines 7 and 2
      bus_write(2'd2, 32'hFE, 4'hF);
      bus_write(2'd1, 32'hFE, 4'hF);
      irq = 7'b1000010;
      step();
      irq = 7'b0;
      repeat (LAT + 1) step();
      chk("t3_seven", {29'h0, interrupt}, 32'h7);
      bus_write(2'd0, 32'h80, 4'hF);
      step();
      chk("t3_two", {29'h0, interrupt}, 32'h2);
      bus_write(2'd0, 32'h04, 4'hF);
      step();
      chk("t3_zero", {29'h0, interrupt}, 32'h0);

      // 4: new edge on line 5 coincides with its clear -> stays pending
      irq = 7'b0010000;
      step();
      irq = 7'b0;
      repeat (LAT) step();
      irq = 7'b0010000;
      repeat (SYNC) step();
      bus_write(2'd0, 32'h20, 4'hF);
      irq = 7'b0;
      bus_read(2'd0, d);
      chk("t4_pend5", {31'h0, d[5]}, 32'h1);

      // 5: int_en gating with line 4 pending
      repeat (LAT) step();
      bus_write(2'd0, 32'hFE, 4'hF);
      step();
      irq = 7'b0001000;
      step();
      irq = 7'b0;
      repeat (LAT + 1) step();
      chk("t5_four", {29'h0, interrupt}, 32'h4);
      int_en = 0;
      step();
      chk("t5_gated", {29'h0, interrupt}, 32'h0);
      bus_read(2'd0, d);
      chk("t5_pend", d, 32'h10);
      int_en = 1;
      step();
      chk("t5_restored", {29'h0, interrupt}, 32'h4);

      // 6: byteenable[0] low drops the write
      bus_write(2'd1, 32'h0E, 4'hF);
      bus_write(2'd1, 32'hFF, 4'hE);
      bus_read(2'd1, d);
      chk("t6_mask", d, 32'h0000000E);

      // Reset during a read abandons it; next read stalls again
      chipselect = 1; read = 1; address = 2'd1;
      step();
      chipselect = 0; read = 0;
      do_reset();
      bus_read(2'd3, d);

      // Randomized traffic against the model
      bus_write(2'd1, 32'hFE, 4'hF);
      for (int i = 0; i < 400; i++) begin
         irq    = 7'($urandom);
         int_en = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 5))
            0: bus_write(2'($urandom), $urandom, 4'($urandom));
            1: bus_read(2'($urandom_range(0, 2)), d);
            default: step();
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
